internal_data_checker: RTL and testbench
========================================

# internal_data_checker

- Receive-side counterpart of the internal pattern generator.
- Samples a serial data stream on rising edges of the selected data clock and self-synchronises to the pattern chosen by `DAT_PAT`.
- Reports lock status and accumulates saturating mismatch and checked-bit counts for loop-back BER testing.
- Sits after the data-clock mux, in parallel with the external data path.

## Interface
- `SYNC_LEN`, default 32: consecutive correct predictions required to declare lock.
- `WIN_LEN`, default 128: checked bits per loss-of-lock evaluation window.
- `LOSS_THR`, default 16: mismatches within one window that force loss of lock.
- `CNT_W`, default 16: width of `err_cnt`.
- `clk` in 1: system clock.
- `rst` in 1: reset `rst`, synchronous, active-high; clock `clk`.
- `data_clock` in 1: selected data clock, sampled in the `clk` domain.
- `rx_data` in 1: serial data under test.
- `DAT_PAT` in 4: expected pattern. 0 = all zeros, 1 = all ones, 3 = PRBS17 (o[n] = o[n-17] ^ o[n-14]); all other codes are unsupported.
- `clr_cnt` in 1: synchronous clear of `err_cnt` and `bit_cnt`.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-`clk` pulse per counted mismatch.
- `err_cnt` out `CNT_W`: saturating count of mismatches while locked.
- `bit_cnt` out 32: saturating count of bits checked while locked.
- `pat_unsup` out 1: `DAT_PAT` is not 0, 1 or 3.

## Operation
- **Edge detect**
  - `data_clock_d` is registered from `data_clock`.
  - A sample event occurs in any `clk` cycle where `data_clock` = 1 and `data_clock_d` = 0.
  - `rx_data` is sampled in that cycle.
- **Prediction**
  - Modes 0/1: the expected bit is `DAT_PAT[0]`.
  - Mode 3: the expected bit is `hist[16] ^ hist[13]`.
    - `hist` is a 17-bit register; `hist[0]` holds the newest received bit and `hist[16]` the bit 17 samples old.
  - `hist` always shifts in the *received* bit, never the predicted one. The checker is therefore self-synchronising.
  - Consequence: one flipped bit yields 3 mismatches, at offsets 0, +14 and +17 samples.
- **FSM states**: IDLE, FILL, SEARCH, LOCKED.
  - IDLE
    - Entered on reset, or while `pat_unsup` = 1.
    - Leaves to FILL (mode 3) or SEARCH (modes 0/1) once `DAT_PAT` is supported.
  - FILL
    - A 5-bit fill counter counts samples.
    - After 17 samples, go to SEARCH.
  - SEARCH
    - Each sample is compared with its prediction.
    - A match increments `match_cnt`; a mismatch clears it.
    - When `match_cnt` reaches `SYNC_LEN`, go to LOCKED.
    - Mode 3 with `hist` == 0: the sample is treated as a mismatch, because an all-zero stream must never lock.
    - Mismatches in this state are not counted.
  - LOCKED
    - Every sample increments `bit_cnt` and the window counter.
    - A mismatch increments `err_cnt` and the window error count, and pulses `err_pulse`.
    - On the `WIN_LEN`-th sample of a window:
      - If the window error count, including that sample, is ≥ `LOSS_THR`, go to SEARCH with `match_cnt` = 0.
      - Otherwise start a new window.
    - The first window starts at the first sample after lock.
- **`DAT_PAT` change** (value differs from its registered copy) in any state:
  - Next state is IDLE.
  - `match_cnt`, fill counter and window counters clear.
  - `err_cnt` and `bit_cnt` are retained.
- **Counters**
  - `err_cnt` holds at all-ones; `bit_cnt` holds at 2^32−1.
  - `clr_cnt` takes priority over increment, so a same-cycle error leaves the count at 0 while `err_pulse` still fires.

## Timing
- **Reset values**
  - `locked` = 0, `err_pulse` = 0, `err_cnt` = 0, `bit_cnt` = 0, `pat_unsup` = 0.
  - State = IDLE, `hist` = 0, all internal counters = 0.
- A reset mid-operation behaves identically to power-on reset.
- **Latency**: all outputs are registered.
  - `err_pulse`, `err_cnt`, `bit_cnt` and the `locked` edges appear 1 `clk` after the sample-event cycle.
  - `pat_unsup` follows `DAT_PAT` with 1 `clk` latency.
  - `locked` falls 1 `clk` after a `DAT_PAT` change.
- **Throughput**
  - At most one sample per `data_clock` rising edge.
  - `data_clock` high and low phases must each last ≥ 1 `clk`.
- **Minimum lock time**
  - Modes 0/1: `SYNC_LEN` samples.
  - Mode 3: 17 + `SYNC_LEN` = 49 samples at defaults.

## Test plan
- **Constant ones**: `DAT_PAT`=1, `rx_data`=1, 40 `data_clock` edges.
  - `locked` rises 1 `clk` after the 32nd edge.
  - `bit_cnt`=8, `err_cnt`=0.
- **PRBS17 lock and single error**: `DAT_PAT`=3, stream from generator seed 0x1AA00, then flip one bit after lock.
  - Lock after the 49th edge.
  - Exactly 3 `err_pulse`s, at the flip and 14 and 17 samples later; `err_cnt`=3; `locked` stays 1.
- **Loss of lock**: mode 0 locked, then `rx_data`=1 from the first post-lock sample.
  - `err_cnt`=128 at the end of the window.
  - `locked` falls 1 `clk` after the 128th sample.
  - Counting stops afterwards.
- **All-zero input in mode 3**: 500 edges of 0.
  - `locked` never asserts; `err_cnt`=0.
- **Pattern change while locked**: change `DAT_PAT` 1→2.
  - `locked`=0 and `pat_unsup`=1 after 1 `clk`; counts retained.
  - Switch to 0 with zero data: relocks after 32 samples.
- **Clear and reset races**
  - `clr_cnt` in the same cycle as a mismatch: `err_cnt`=0 and `err_pulse`=1.
  - `rst` mid-lock: all outputs are 0 on the next `clk`.
  - Preloaded `err_cnt`=0xFFFF plus an error: stays 0xFFFF.

Source files
------------

// File: rtl/internal_data_checker_if.sv
// Bundles the serial stream, pattern select, counter clear and status/counter outputs of the checker.
// Latency: n/a (signal bundle only).
// Backpressure: none; the stream is sampled on data_clock edges and never stalled.
interface internal_data_checker_if #(
    parameter int CNT_W = 16
);
    logic             data_clock;
    logic             rx_data;
    logic [3:0]       DAT_PAT;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [31:0]      bit_cnt;
    logic             pat_unsup;

    modport master (
        output data_clock, rx_data, DAT_PAT, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt, pat_unsup
    );

    modport slave (
        input  data_clock, rx_data, DAT_PAT, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt, pat_unsup
    );
endinterface

// File: rtl/internal_data_checker.sv
// Self-synchronising serial pattern checker (zeros, ones, PRBS17) with lock FSM and saturating BER counters.
// Latency: every output is registered, 1 clk after the data_clock sampling cycle or DAT_PAT change.
// Backpressure: none; at most one sample per data_clock rising edge, every sample is consumed.
module internal_data_checker #(
    parameter int SYNC_LEN = 32,
    parameter int WIN_LEN  = 128,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    internal_data_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, SEARCH, LOCKED} state_t;

    localparam int MW = $clog2(SYNC_LEN + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
    localparam logic [WW-1:0] LOSS_LIM  = WW'(LOSS_THR);

    state_t           state, state_nxt;
    logic             data_clock_d;
    logic [3:0]       dat_pat_q;
    logic [16:0]      hist;
    logic [4:0]       fill_cnt;
    logic [MW-1:0]    match_cnt;
    logic [WW-1:0]    win_cnt;
    logic [WW-1:0]    win_err;
    logic [CNT_W-1:0] err_cnt_q;
    logic [31:0]      bit_cnt_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             pat_unsup_q;

    logic sample, pat_change, pat_ok, mode3, pred, miss, search_miss;
    logic fill_inc, fill_clr, match_inc, match_clr, win_inc, win_clr, cnt_bit, cnt_err;

    assign sample      = bus.data_clock & ~data_clock_d;
    assign pat_change  = bus.DAT_PAT != dat_pat_q;
    assign pat_ok      = (bus.DAT_PAT == 4'd0) || (bus.DAT_PAT == 4'd1) || (bus.DAT_PAT == 4'd3);
    assign mode3       = dat_pat_q == 4'd3;
    assign pred        = mode3 ? (hist[16] ^ hist[13]) : dat_pat_q[0];
    assign miss        = bus.rx_data != pred;
    // An all-zero history would predict zeros forever, so it must never count as a match.
    assign search_miss = miss | (mode3 & (hist == 17'd0));

    // Edge detector, pattern shadow copy and pattern-support flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_clock_d <= 1'b0;
            dat_pat_q    <= 4'd0;
            pat_unsup_q  <= 1'b0;
        end else begin
            data_clock_d <= bus.data_clock;
            dat_pat_q    <= bus.DAT_PAT;
            pat_unsup_q  <= ~pat_ok;
        end
    end

    // History always shifts in the received bit so the predictor resynchronises by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 17'd0;
        end else if (sample) begin
            hist <= {hist[15:0], bus.rx_data};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter strobes; a pattern change overrides everything and drops to IDLE.
    always_comb begin
        state_nxt = state;
        fill_inc  = 1'b0;
        fill_clr  = 1'b0;
        match_inc = 1'b0;
        match_clr = 1'b0;
        win_inc   = 1'b0;
        win_clr   = 1'b0;
        cnt_bit   = 1'b0;
        cnt_err   = 1'b0;
        if (pat_change) begin
            state_nxt = IDLE;
            fill_clr  = 1'b1;
            match_clr = 1'b1;
            win_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pat_ok) begin
                        state_nxt = mode3 ? FILL : SEARCH;
                    end
                end
                FILL: begin
                    if (sample) begin
                        if (fill_cnt == 5'd16) begin
                            state_nxt = SEARCH;
                            fill_clr  = 1'b1;
                        end else begin
                            fill_inc = 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (sample) begin
                        if (search_miss) begin
                            match_clr = 1'b1;
                        end else if (match_cnt == SYNC_LAST) begin
                            state_nxt = LOCKED;
                            match_clr = 1'b1;
                            win_clr   = 1'b1;
                        end else begin
                            match_inc = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (sample) begin
                        cnt_bit = 1'b1;
                        cnt_err = miss;
                        if (win_cnt == WIN_LAST) begin
                            win_clr = 1'b1;
                            if ((win_err + WW'(miss)) >= LOSS_LIM) begin
                                state_nxt = SEARCH;
                                match_clr = 1'b1;
                            end
                        end else begin
                            win_inc = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Fill, match and loss-of-lock window counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt  <= 5'd0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else begin
            if (fill_clr)       fill_cnt <= 5'd0;
            else if (fill_inc)  fill_cnt <= fill_cnt + 5'd1;
            if (match_clr)      match_cnt <= '0;
            else if (match_inc) match_cnt <= match_cnt + 1'b1;
            if (win_clr) begin
                win_cnt <= '0;
                win_err <= '0;
            end else if (win_inc) begin
                win_cnt <= win_cnt + 1'b1;
                win_err <= win_err + WW'(miss);
            end
        end
    end

    // Saturating BER counters (clear wins over increment) and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q   <= '0;
            bit_cnt_q   <= 32'd0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            if (bus.clr_cnt)                      err_cnt_q <= '0;
            else if (cnt_err && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 1'b1;
            if (bus.clr_cnt)                      bit_cnt_q <= 32'd0;
            else if (cnt_bit && bit_cnt_q != '1)  bit_cnt_q <= bit_cnt_q + 32'd1;
            err_pulse_q <= cnt_err;
            locked_q    <= state_nxt == LOCKED;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.pat_unsup = pat_unsup_q;
endmodule

// File: tb/tb_internal_data_checker.sv
// Bench for internal_data_checker: directed scenarios plus random streams against a sample-level model.
// Latency: outputs checked on the falling clk edge one cycle after each sampling cycle.
// Backpressure: none; bench drives one data_clock rising edge every three clk cycles.
module tb_internal_data_checker;
    localparam int SYNC_LEN = 32;
    localparam int WIN_LEN  = 128;
    localparam int LOSS_THR = 16;
    localparam int CNT_W    = 8;
    localparam longint ERR_MAX = (64'd1 << CNT_W) - 1;
    localparam longint BIT_MAX = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    internal_data_checker_if #(.CNT_W(CNT_W)) bus ();

    internal_data_checker #(
        .SYNC_LEN(SYNC_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model, one step per received bit.
    int     m_pat;
    bit     m_active, m_lock, m_pulse;
    int     m_fill, m_run, m_wn, m_we;
    longint m_err, m_bits;
    bit     hq[$];       // last 17 received bits, oldest first

    // Values observed right after the most recent sample.
    bit     obs_lock, obs_pulse;
    longint obs_err, obs_bits;

    logic [16:0] lfsr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit sup(input int p);
        return (p == 0) || (p == 1) || (p == 3);
    endfunction

    function automatic bit prbs_next();
        bit o;
        o = lfsr[16] ^ lfsr[13];
        lfsr = {lfsr[15:0], o};
        return o;
    endfunction

    task automatic model_reset(input int p);
        m_pat = p; m_active = sup(p); m_lock = 0; m_pulse = 0;
        m_fill = 0; m_run = 0; m_wn = 0; m_we = 0; m_err = 0; m_bits = 0;
        hq.delete();
        for (int i = 0; i < 17; i++) hq.push_back(1'b0);
    endtask

    task automatic model_change(input int p);
        if (p != m_pat) begin
            m_pat = p; m_active = sup(p); m_lock = 0;
            m_fill = 0; m_run = 0; m_wn = 0; m_we = 0;
        end
    endtask

    task automatic model_sample(input bit b, input bit clr);
        bit pred, zero, bad;
        m_pulse = 0;
        if (m_active) begin
            pred = (m_pat == 3) ? (hq[0] ^ hq[3]) : bit'(m_pat % 2);
            zero = 1;
            foreach (hq[i]) if (hq[i]) zero = 0;
            bad = (b != pred);
            if (!m_lock && m_pat == 3 && m_fill < 17) begin
                m_fill++;
            end else if (!m_lock) begin
                if (!bad && !(m_pat == 3 && zero)) m_run++;
                else m_run = 0;
                if (m_run == SYNC_LEN) begin
                    m_lock = 1; m_run = 0; m_wn = 0; m_we = 0;
                end
            end else begin
                if (m_bits < BIT_MAX) m_bits++;
                if (bad) begin
                    m_pulse = 1; m_we++;
                    if (m_err < ERR_MAX) m_err++;
                end
                m_wn++;
                if (m_wn == WIN_LEN) begin
                    if (m_we >= LOSS_THR) begin
                        m_lock = 0; m_run = 0;
                    end
                    m_wn = 0; m_we = 0;
                end
            end
        end
        if (clr) begin
            m_err = 0; m_bits = 0;
        end
        hq.push_back(b);
        void'(hq.pop_front());
    endtask

    task automatic send_bit(input bit b, input bit clr);
        @(negedge clk);
        bus.rx_data = b; bus.clr_cnt = clr; bus.data_clock = 1'b1;
        model_sample(b, clr);
        @(negedge clk);
        bus.data_clock = 1'b0; bus.clr_cnt = 1'b0;
        obs_lock = bus.locked; obs_pulse = bus.err_pulse;
        obs_err = 64'(bus.err_cnt); obs_bits = 64'(bus.bit_cnt);
        check("locked", 64'(bus.locked), 64'(m_lock));
        check("err_pulse", 64'(bus.err_pulse), 64'(m_pulse));
        check("err_cnt", 64'(bus.err_cnt), m_err);
        check("bit_cnt", 64'(bus.bit_cnt), m_bits);
        check("pat_unsup", 64'(bus.pat_unsup), 64'(!sup(m_pat)));
        @(negedge clk);
        check("pulse_width", 64'(bus.err_pulse), 64'd0);
    endtask

    task automatic set_pat(input int p);
        @(negedge clk);
        bus.DAT_PAT = 4'(p);
        model_change(p);
        @(negedge clk);
        check("chg_locked", 64'(bus.locked), 64'(m_lock));
        check("chg_unsup", 64'(bus.pat_unsup), 64'(!sup(p)));
        check("chg_err_cnt", 64'(bus.err_cnt), m_err);
        check("chg_bit_cnt", 64'(bus.bit_cnt), m_bits);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int p);
        @(negedge clk);
        rst = 1'b1; bus.DAT_PAT = 4'(p); bus.data_clock = 1'b0; bus.clr_cnt = 1'b0;
        model_reset(p);
        @(negedge clk);
        check("rst_locked", 64'(bus.locked), 64'd0);
        check("rst_pulse", 64'(bus.err_pulse), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        check("rst_bit_cnt", 64'(bus.bit_cnt), 64'd0);
        check("rst_unsup", 64'(bus.pat_unsup), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int pulses[$];
        bit ever_locked;
        bus.data_clock = 1'b0; bus.rx_data = 1'b0; bus.DAT_PAT = 4'd0; bus.clr_cnt = 1'b0;
        repeat (2) @(negedge clk);

        // Constant ones: lock on the 32nd sample, 8 bits counted by the 40th.
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b1, 1'b0);
            if (i == 30) check("ones_prelock", 64'(obs_lock), 64'd0);
            if (i == 31) check("ones_lock", 64'(obs_lock), 64'd1);
        end
        check("ones_bits", obs_bits, 64'd8);
        check("ones_errs", obs_err, 64'd0);

        // Pattern change while locked: unsupported code, then relock in mode 0.
        set_pat(2);
        check("pat2_unsup", 64'(bus.pat_unsup), 64'd1);
        check("pat2_locked", 64'(bus.locked), 64'd0);
        check("pat2_bits_kept", 64'(bus.bit_cnt), 64'd8);
        set_pat(0);
        for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
        check("relock0", 64'(obs_lock), 64'd1);

        // Clear in the same cycle as a counted mismatch.
        send_bit(1'b1, 1'b1);
        check("clr_race_cnt", obs_err, 64'd0);
        check("clr_race_pulse", 64'(obs_pulse), 64'd1);

        // Reset while locked (output checks inside do_reset), then loss of lock in mode 0.
        do_reset(0);
        for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
        check("loss_lock", 64'(obs_lock), 64'd1);
        for (int i = 0; i < 128; i++) begin
            send_bit(1'b1, 1'b0);
            if (i == 126) check("loss_still", 64'(obs_lock), 64'd1);
        end
        check("loss_errs", obs_err, 64'd128);
        check("loss_unlock", 64'(obs_lock), 64'd0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        check("loss_stopped", obs_err, 64'd128);

        // Second loss window drives err_cnt into saturation.
        for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
        for (int i = 0; i < 128; i++) send_bit(1'b1, 1'b0);
        check("sat_errs", obs_err, ERR_MAX);

        // PRBS17: lock on the 49th sample, one flipped bit gives three pulses.
        do_reset(3);
        lfsr = 17'h1AA00;
        for (int i = 0; i < 49; i++) begin
            send_bit(prbs_next(), 1'b0);
            if (i == 47) check("prbs_prelock", 64'(obs_lock), 64'd0);
        end
        check("prbs_lock", 64'(obs_lock), 64'd1);
        for (int i = 0; i < 10; i++) send_bit(prbs_next(), 1'b0);
        for (int j = 0; j < 30; j++) begin
            send_bit(prbs_next() ^ (j == 0), 1'b0);
            if (obs_pulse) pulses.push_back(j);
        end
        check("prbs_npulse", 64'(pulses.size()), 64'd3);
        if (pulses.size() == 3) begin
            check("prbs_p0", 64'(pulses[0]), 64'd0);
            check("prbs_p1", 64'(pulses[1]), 64'd14);
            check("prbs_p2", 64'(pulses[2]), 64'd17);
        end
        check("prbs_errs", obs_err, 64'd3);
        check("prbs_kept_lock", 64'(obs_lock), 64'd1);

        // All-zero stream in PRBS mode must never lock.
        do_reset(3);
        ever_locked = 0;
        for (int i = 0; i < 500; i++) begin
            send_bit(1'b0, 1'b0);
            if (obs_lock) ever_locked = 1;
        end
        check("zero_never_lock", 64'(ever_locked), 64'd0);
        check("zero_errs", obs_err, 64'd0);

        // Random segments: random pattern codes, error densities and counter clears.
        do_reset(0);
        for (int s = 0; s < 12; s++) begin
            int pats[6];
            int p, n, rate;
            bit b;
            pats = '{0, 1, 3, 3, 2, 7};
            p = pats[$urandom_range(0, 5)];
            set_pat(p);
            n = $urandom_range(60, 220);
            rate = $urandom_range(3, 80);
            for (int i = 0; i < n; i++) begin
                if (p == 3) b = prbs_next();
                else if (sup(p)) b = bit'(p % 2);
                else b = 1'($urandom);
                if ($urandom_range(0, rate - 1) == 0) b = ~b;
                send_bit(b, $urandom_range(0, 63) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
